// File: rtl/mmio_node_logger_if.sv
// Snoop bus for the CPU data-memory write port. The CPU (or the bench)
// drives it; the node logger only observes it.
interface mmio_node_logger_if;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;

   modport master (output MemWrite, output DataAdr, output WriteData);
   modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/mmio_node_logger.sv
// Node-point store logger. Watches the CPU store port, queues every node
// store into a show-ahead FIFO for a host consumer, and latches the
// CPU-done store as a sticky flag. Once done, further node stores are
// ignored until reset or clear. DEPTH must be a power of two and >= 2 so
// that the pointers wrap by plain binary overflow.
module mmio_node_logger #(
   parameter logic [31:0] NODE_ADDR = 32'h0200_0008,
   parameter logic [31:0] DONE_ADDR = 32'h0200_000C,
   parameter int unsigned NODE_W    = 5,
   parameter int unsigned DEPTH     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   mmio_node_logger_if.slave        snoop,
   input  logic                     clear,
   input  logic                     node_ready,
   output logic                     node_valid,
   output logic [NODE_W-1:0]        node_data,
   output logic [$clog2(DEPTH):0]   node_count,
   output logic [7:0]               total_nodes,
   output logic                     done,
   output logic                     overflow,
   output logic                     range_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [AW-1:0]     PTR_ZERO   = AW'(0);
   localparam logic [AW-1:0]     PTR_ONE    = AW'(1);
   localparam logic [CW-1:0]     CNT_ZERO   = CW'(0);
   localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
   localparam logic [CW-1:0]     CNT_FULL   = CW'(DEPTH);
   localparam logic [NODE_W-1:0] NODE_ZERO  = NODE_W'(0);

   typedef enum logic [0:0] {
      ST_ARMED = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [NODE_W-1:0]   mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [7:0]          total_q, total_d;
   logic                ovf_q, ovf_d;
   logic                rerr_q, rerr_d;

   logic                node_store_s;
   logic                done_store_s;
   logic                high_bits_s;
   logic                armed_s;
   logic                empty_s;
   logic                full_s;
   logic                pop_s;
   logic                push_req_s;
   logic                push_s;
   logic                drop_s;
   logic                wr_en_s;

   // Store decode and FIFO handshake qualifiers
   always_comb begin
      node_store_s = snoop.MemWrite && (snoop.DataAdr == NODE_ADDR);
      done_store_s = snoop.MemWrite && (snoop.DataAdr == DONE_ADDR)
                     && (snoop.WriteData == 32'h0000_0001);
      high_bits_s  = ((snoop.WriteData >> NODE_W) != 32'h0000_0000);
      armed_s      = (state_q == ST_ARMED);
      empty_s      = (count_q == CNT_ZERO);
      full_s       = (count_q == CNT_FULL);
      pop_s        = !empty_s && node_ready;
      push_req_s   = armed_s && node_store_s;
      // A full FIFO still accepts a push when the head leaves in the same cycle
      push_s       = push_req_s && (!full_s || pop_s);
      drop_s       = push_req_s && full_s && !pop_s;
      wr_en_s      = push_s && !clear;
   end

   // Next-state logic for the armed/done controller; clear wins over a done store
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ARMED: begin
            if (clear) begin
               state_d = ST_ARMED;
            end else if (done_store_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ARMED;
            end
         end
         ST_DONE: begin
            if (clear) begin
               state_d = ST_ARMED;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_ARMED;
         end
      endcase
   end

   // Next-state logic for pointers, occupancy, node total and sticky flags
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      total_d  = total_q;
      ovf_d    = ovf_q;
      rerr_d   = rerr_q;
      if (clear) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         count_d  = CNT_ZERO;
         total_d  = 8'd0;
         ovf_d    = 1'b0;
         rerr_d   = 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (push_s && (total_q != 8'd255)) begin
            total_d = total_q + 8'd1;
         end else begin
            total_d = total_q;
         end
         ovf_d  = ovf_q | drop_s;
         // Flagged on every node store in ARMED, whether accepted or dropped
         rerr_d = rerr_q | (push_req_s && high_bits_s);
      end
   end

   // Controller, pointer, counter and flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_ARMED;
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
         total_q  <= 8'd0;
         ovf_q    <= 1'b0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         total_q  <= total_d;
         ovf_q    <= ovf_d;
         rerr_q   <= rerr_d;
      end
   end

   // FIFO storage; the truncated node value lands at the write pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= NODE_ZERO;
         end
      end else if (wr_en_s) begin
         mem_q[wr_ptr_q] <= snoop.WriteData[NODE_W-1:0];
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   // Outputs come straight from registers; the head reads as zero when empty
   always_comb begin
      node_valid  = !empty_s;
      node_count  = count_q;
      total_nodes = total_q;
      done        = (state_q == ST_DONE);
      overflow    = ovf_q;
      range_err   = rerr_q;
      if (empty_s) begin
         node_data = NODE_ZERO;
      end else begin
         node_data = mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_mmio_node_logger.sv
// Self-checking bench for mmio_node_logger: directed scenarios with literal
// expectations, then randomized store traffic compared every cycle against
// a queue-based model of the logger's behaviour.
module tb_mmio_node_logger;

   localparam logic [31:0] NODE_A  = 32'h0200_0008;
   localparam logic [31:0] DONE_A  = 32'h0200_000C;
   localparam logic [31:0] OTHER_A = 32'h0200_0004;
   localparam int          DEPTH   = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       node_ready;
   logic       node_valid;
   logic [4:0] node_data;
   logic [4:0] node_count;
   logic [7:0] total_nodes;
   logic       done;
   logic       overflow;
   logic       range_err;

   mmio_node_logger_if bus();

   mmio_node_logger #(
      .NODE_ADDR (NODE_A),
      .DONE_ADDR (DONE_A),
      .NODE_W    (5),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .snoop       (bus),
      .clear       (clear),
      .node_ready  (node_ready),
      .node_valid  (node_valid),
      .node_data   (node_data),
      .node_count  (node_count),
      .total_nodes (total_nodes),
      .done        (done),
      .overflow    (overflow),
      .range_err   (range_err)
   );

   always #5 clk = ~clk;

   // Behavioural model: queue of node values plus plain flags
   int unsigned mq[$];
   int          m_total;
   bit          m_done, m_ovf, m_rerr;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_total = 0;
      m_done  = 0;
      m_ovf   = 0;
      m_rerr  = 0;
   endtask

   // One clock edge of the logger, written from the behavioural rules
   task automatic model_step();
      bit popping, accept;
      int unsigned val;
      if (clear) begin
         model_reset();
         return;
      end
      popping = (mq.size() != 0) && node_ready;
      accept  = 0;
      val     = bus.WriteData % 32;
      if (!m_done && bus.MemWrite && bus.DataAdr == NODE_A) begin
         if (bus.WriteData > 32'd31) m_rerr = 1;
         if (mq.size() < DEPTH || popping) accept = 1;
         else m_ovf = 1;
      end
      if (popping) void'(mq.pop_front());
      if (accept) begin
         mq.push_back(val);
         if (m_total < 255) m_total++;
      end
      if (!m_done && bus.MemWrite && bus.DataAdr == DONE_A && bus.WriteData == 32'd1)
         m_done = 1;
   endtask

   // Compare every output against the model on each falling edge out of reset
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("node_valid",  node_valid,  (mq.size() != 0));
         chk("node_data",   node_data,   (mq.size() != 0) ? mq[0] : 0);
         chk("node_count",  node_count,  mq.size());
         chk("total_nodes", total_nodes, m_total);
         chk("done",        done,        m_done);
         chk("overflow",    overflow,    m_ovf);
         chk("range_err",   range_err,   m_rerr);
      end
   end

   task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy, input logic clr);
      bus.MemWrite  = mw;
      bus.DataAdr   = adr;
      bus.WriteData = wd;
      node_ready    = rdy;
      clear         = clr;
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic node(input logic [31:0] v);
      step(1'b1, NODE_A, v, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
   endtask

   task automatic do_clear();
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, node_valid,  1'b0);
      chk({tag, "_data"},  node_data,   5'd0);
      chk({tag, "_count"}, node_count,  5'd0);
      chk({tag, "_total"}, total_nodes, 8'd0);
      chk({tag, "_done"},  done,        1'b0);
      chk({tag, "_ovf"},   overflow,    1'b0);
      chk({tag, "_rerr"},  range_err,   1'b0);
   endtask

   initial begin
      int vals[4];
      int rdy_pct;
      vals = '{3, 7, 12, 31};

      rst_n         = 1'b0;
      clear         = 1'b0;
      node_ready    = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.DataAdr   = 32'h0;
      bus.WriteData = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Capture sequence
      foreach (vals[k]) node(vals[k]);
      step(1'b1, DONE_A, 32'd1, 1'b0, 1'b0);
      chk("cap_count", node_count, 5'd4);
      chk("cap_total", total_nodes, 8'd4);
      chk("cap_done",  done, 1'b1);
      node(32'd9);
      chk("cap_after_done_count", node_count, 5'd4);
      foreach (vals[k]) begin
         chk("cap_pop_data", node_data, vals[k]);
         idle(1'b1);
      end
      chk("cap_empty", node_valid, 1'b0);

      // Overflow, then full FIFO with simultaneous push and pop
      do_clear();
      for (int v = 0; v <= 16; v++) node(v);
      chk("ovf_count", node_count, 5'd16);
      chk("ovf_flag",  overflow, 1'b1);
      chk("ovf_total", total_nodes, 8'd16);
      chk("ovf_head",  node_data, 5'd0);
      step(1'b1, NODE_A, 32'd20, 1'b1, 1'b0);
      chk("full_pushpop_count", node_count, 5'd16);
      for (int k = 0; k < 16; k++) begin
         chk("full_drain_data", node_data, (k < 15) ? k + 1 : 20);
         idle(1'b1);
      end

      // Done filtering
      do_clear();
      step(1'b1, DONE_A, 32'd0, 1'b0, 1'b0);
      step(1'b1, DONE_A, 32'd2, 1'b0, 1'b0);
      chk("filter_done_low", done, 1'b0);
      step(1'b1, DONE_A, 32'd1, 1'b0, 1'b0);
      chk("filter_done_set", done, 1'b1);

      // Range error
      do_clear();
      node(32'h0000_0025);
      chk("range_flag", range_err, 1'b1);
      chk("range_data", node_data, 5'h05);
      step(1'b1, OTHER_A, 32'd3, 1'b0, 1'b0);
      chk("range_other_count", node_count, 5'd1);

      // Clear priority
      do_clear();
      node(32'd1); node(32'd2); node(32'd3);
      step(1'b1, DONE_A, 32'd1, 1'b0, 1'b0);
      chk("clrpri_pre_count", node_count, 5'd3);
      step(1'b1, NODE_A, 32'd9, 1'b1, 1'b1);
      chk("clrpri_count", node_count, 5'd0);
      chk("clrpri_valid", node_valid, 1'b0);
      chk("clrpri_done",  done, 1'b0);
      chk("clrpri_total", total_nodes, 8'd0);
      idle(1'b0);
      chk("clrpri_no9", node_count, 5'd0);

      // Asynchronous reset mid-run
      do_clear();
      node(32'd1); node(32'h45); node(32'd2); node(32'd3); node(32'd4);
      step(1'b1, DONE_A, 32'd1, 1'b0, 1'b0);
      chk("arst_pre_count", node_count, 5'd5);
      bus.MemWrite = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_all_zero("arst");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      node(32'd4);
      chk("arst_first_count", node_count, 5'd1);

      // Randomized traffic
      do_clear();
      rdy_pct = 50;
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [31:0] adr, wd;
         if (i % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       rdy_pct = 10;
               1:       rdy_pct = 50;
               default: rdy_pct = 90;
            endcase
         end
         r = $urandom_range(0, 99);
         if (r < 45)      adr = NODE_A;
         else if (r < 55) adr = DONE_A;
         else if (r < 70) adr = OTHER_A;
         else             adr = $urandom;
         if (adr == DONE_A)
            wd = ($urandom_range(0, 4) == 0) ? 32'd1 : $urandom_range(0, 3);
         else if ($urandom_range(0, 99) < 85)
            wd = $urandom_range(0, 31);
         else
            wd = $urandom;
         step($urandom_range(0, 3) != 0, adr, wd,
              $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
